// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small circular byte FIFO.
// Line, active and done outputs are all driven straight from registers.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             i_Clock,
  input  logic                             i_Rst_n,
  input  logic                             i_TX_DV,
  input  logic [7:0]                       i_TX_Byte,
  output logic                             o_TX_Ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_FIFO_Count,
  output logic                             o_TX_Active,
  output logic                             o_TX_Serial,
  output logic                             o_TX_Done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] DEPTH_N = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NW-1:0] count_q, count_d;
  logic          push, pop;

  state_e        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          serial_q, serial_d;
  logic          active_q, active_d;
  logic          done_q, done_d;

  // Ready uses the pre-pop count, so a write while full is dropped
  assign o_TX_Ready   = count_q < DEPTH_N;
  assign push         = i_TX_DV & o_TX_Ready;
  assign pop          = (state_q == S_IDLE) && (count_q != '0);
  assign count_d      = count_q + NW'(push) - NW'(pop);
  assign o_FIFO_Count = count_q;
  assign o_TX_Active  = active_q;
  assign o_TX_Serial  = serial_q;
  assign o_TX_Done    = done_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= i_TX_Byte;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        if (pop) begin
          shift_d   = mem_q[rd_ptr_q];
          clk_cnt_d = '0;
          bit_idx_d = '0;
          serial_d  = 1'b0;
          active_d  = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          serial_d  = shift_q[0];
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            serial_d  = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          serial_d  = 1'b1;
          active_d  = 1'b0;
          done_d    = 1'b1;
          state_d   = S_CLEANUP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_CLEANUP: begin
        serial_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed writes feed a byte scoreboard,
// a reference receiver decodes the line and checks frame shape and order.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       ready, active, serial, done;
  logic [2:0] fcnt;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_TX_DV     (dv),
    .i_TX_Byte   (tx_byte),
    .o_TX_Ready  (ready),
    .o_FIFO_Count(fcnt),
    .o_TX_Active (active),
    .o_TX_Serial (serial),
    .o_TX_Done   (done)
  );

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  int         low_runs[$];
  int         rx_frames = 0;
  int         done_cnt = 0;
  int         max_cnt = 0;
  bit         gap_chk = 1'b0;
  logic       smp [40];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (int'(fcnt) > max_cnt) max_cnt = int'(fcnt);
  end

  // Reference receiver: samples every cycle, checks whole bit periods
  initial begin : monitor
    int         hi_run;
    int         bad;
    int         lr;
    int         per;
    bit         have_prev;
    bit         abort;
    logic       eb;
    logic [7:0] rx;
    logic [7:0] e;
    hi_run    = 0;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && serial === 1'b0) begin
        if (gap_chk && have_prev) chk("frame_gap", hi_run + CPB, CPB + 2);
        smp[0] = 1'b0;
        abort  = 1'b0;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          if (!rst_n) begin
            abort = 1'b1;
            break;
          end
          smp[k] = serial;
        end
        if (!abort) begin
          bad = 0;
          rx  = 8'h00;
          e   = 8'h00;
          chk("exp_avail", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) e = exp_q.pop_front();
          for (int k = 0; k < 40; k++) begin
            per = k / CPB;
            if (per == 0) eb = 1'b0;
            else if (per == 9) eb = 1'b1;
            else eb = e[per-1];
            if (smp[k] !== eb) bad++;
          end
          for (int i = 0; i < 8; i++) rx[i] = smp[(i+1)*CPB + CPB/2];
          lr = 0;
          while (lr < 40 && smp[lr] === 1'b0) lr++;
          low_runs.push_back(lr);
          rx_frames++;
          chk("frame_shape", bad, 0);
          chk("rx_byte", rx, e);
          chk("stop_bit", smp[9*CPB + CPB/2], 1);
          @(negedge clk);
          if (rst_n) chk("done_after_frame", done, 1);
          hi_run    = 1;
          have_prev = 1'b1;
        end else begin
          hi_run    = 0;
          have_prev = 1'b0;
        end
      end else begin
        hi_run++;
      end
    end
  end

  task automatic wr(input logic [7:0] b);
    int   g;
    logic acc;
    g       = 0;
    tx_byte = b;
    dv      = 1'b1;
    do begin
      acc = ready;
      @(posedge clk);
      #1;
      g++;
    end while (!acc && g < 2000);
    dv = 1'b0;
    if (acc) exp_q.push_back(b);
    else chk("write_accept", acc, 1);
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || active || fcnt != 0) && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({"drain_", name}, exp_q.size(), 0);
  endtask

  initial begin : stim
    int f0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_serial", serial, 1);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 1);
    chk("rst_count", fcnt, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_serial", serial, 1);

    // single byte, start one cycle after the write
    f0       = rx_frames;
    done_cnt = 0;
    wr(8'hA5);
    chk("t1_pre_start", serial, 1);
    chk("t1_count", fcnt, 1);
    @(posedge clk);
    #1;
    chk("t1_start_edge", serial, 0);
    chk("t1_active", active, 1);
    drain("t1");
    chk("t1_frames", rx_frames - f0, 1);
    chk("t1_done_cnt", done_cnt, 1);

    // burst of six: the sixth meets a full FIFO
    f0       = rx_frames;
    done_cnt = 0;
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    dv = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tx_byte = 8'(i);
      if (i == 6) begin
        chk("t2_ready_full", ready, 0);
        chk("t2_count_full", fcnt, 4);
      end
      @(posedge clk);
      #1;
    end
    dv      = 1'b0;
    gap_chk = 1'b1;
    drain("t2");
    gap_chk = 1'b0;
    chk("t2_frames", rx_frames - f0, 5);
    chk("t2_done_cnt", done_cnt, 5);

    // pointer wrap-around
    f0      = rx_frames;
    max_cnt = 0;
    for (int i = 0; i < 12; i++) wr(8'h40 + 8'(i));
    drain("t3");
    chk("t3_frames", rx_frames - f0, 12);
    chk("t3_max_count", max_cnt, 4);

    // write on the pop cycle
    f0 = rx_frames;
    wr(8'h11);
    wr(8'h3C);
    chk("t4_count_same", fcnt, 1);
    chk("t4_active", active, 1);
    drain("t4");
    chk("t4_frames", rx_frames - f0, 2);

    // reset during data bit 3 with two bytes queued
    wr(8'hFF);
    wr(8'h12);
    wr(8'h34);
    chk("t5_queued", fcnt, 2);
    repeat (16) @(posedge clk);
    #1;
    chk("t5_mid_frame", active, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_serial", serial, 1);
    chk("t5_rst_count", fcnt, 0);
    chk("t5_rst_active", active, 0);
    chk("t5_rst_ready", ready, 1);
    exp_q.delete();
    f0       = rx_frames;
    done_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("t5_no_frames", rx_frames - f0, 0);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_line_high", serial, 1);
    chk("t5_count_zero", fcnt, 0);

    // extreme data values back-to-back
    f0 = rx_frames;
    low_runs.delete();
    wr(8'h00);
    wr(8'hFF);
    gap_chk = 1'b1;
    drain("t6");
    gap_chk = 1'b0;
    chk("t6_frames", rx_frames - f0, 2);
    chk("t6_low_00", low_runs[0], 9*CPB);
    chk("t6_low_ff", low_runs[1], CPB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
